// File: rtl/scope_pkg.sv
// Shared state encoding and constants for the scope_capture acquisition engine.
package scope_pkg;

   localparam int unsigned cSampleBits = 8;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PRE  = 3'd1,
      WAIT = 3'd2,
      POST = 3'd3,
      DONE = 3'd4
   } tScopeState;

   localparam logic cEdgeFalling = 1'b0;
   localparam logic cEdgeRising  = 1'b1;

endpackage

// File: rtl/scope_sample_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
module scope_sample_ram
   import scope_pkg::*;
#(
   parameter int unsigned pDepthBits = 10
) (
   input  logic                   iCLK,
   input  logic                   iRST,
   input  logic                   iWrEn,
   input  logic [pDepthBits-1:0]  iWrAddr,
   input  logic [cSampleBits-1:0] iWrData,
   input  logic                   iRdEn,
   input  logic [pDepthBits-1:0]  iRdAddr,
   output logic [cSampleBits-1:0] oRdData
);

   localparam int unsigned cDepth = 1 << pDepthBits;

   logic [cSampleBits-1:0] mem [cDepth];

   always_ff @(posedge iCLK) begin
      if (iWrEn) mem[iWrAddr] <= iWrData;
   end

   // Only the read register is reset so the readout port starts at zero.
   always_ff @(posedge iCLK) begin
      if (iRST)       oRdData <= '0;
      else if (iRdEn) oRdData <= mem[iRdAddr];
   end

endmodule

// File: rtl/scope_capture.sv
// ADC capture engine: circular pre-trigger buffer, edge trigger and ordered readout.
// Optional forced trigger after a WAIT timeout is enabled by defining SCOPE_AUTO_TRIG_EN.
module scope_capture
   import scope_pkg::*;
#(
   parameter int unsigned pDepthBits       = 10,
   parameter int unsigned pPreTrig         = 256,
   parameter int unsigned pAutoTrigTimeout = 20000
) (
   input  logic                   iCLK,
   input  logic                   iRST,
   input  logic                   iSampleStrobe,
   input  logic [cSampleBits-1:0] iADC_Byte,
   input  logic                   iArm,
   input  logic [cSampleBits-1:0] iTrigLevel,
   input  logic                   iTrigRising,
   input  logic                   iRdReq,
   output logic [cSampleBits-1:0] oRdData,
   output logic                   oRdValid,
   output logic                   oArmed,
   output logic                   oTriggered,
   output logic                   oDone
);

   localparam int unsigned cDepth      = 1 << pDepthBits;
   localparam int unsigned cPostLen    = cDepth - pPreTrig;
   localparam logic        cPostSingle = (cPostLen == 1);

   tScopeState            state, stateNext;
   logic [pDepthBits-1:0] wptr, tptr, cnt, cntNext, rdAddr;
   logic [cSampleBits-1:0] rPrev;
   logic                  wrEn, rdAccept, trigFire, edgeHit, trigHit;

   assign wrEn = iSampleStrobe && ((state == PRE) || (state == WAIT) || (state == POST));

   assign edgeHit = (iTrigRising == cEdgeRising)
                  ? ((rPrev <  iTrigLevel) && (iADC_Byte >= iTrigLevel))
                  : ((rPrev >= iTrigLevel) && (iADC_Byte <  iTrigLevel));

`ifdef SCOPE_AUTO_TRIG_EN
   localparam int unsigned cAutoBits = $clog2(pAutoTrigTimeout + 1);
   logic [cAutoBits-1:0] autoCnt;

   assign trigHit = edgeHit || (autoCnt == cAutoBits'(pAutoTrigTimeout - 1));

   // Counts WAIT strobes since entry into WAIT.
   always_ff @(posedge iCLK) begin
      if (iRST)                                    autoCnt <= '0;
      else if (state == PRE && stateNext == WAIT)  autoCnt <= '0;
      else if (state == WAIT && iSampleStrobe)     autoCnt <= autoCnt + 1'b1;
   end
`else
   assign trigHit = edgeHit;
`endif

   always_ff @(posedge iCLK) begin
      if (iRST) state <= IDLE;
      else      state <= stateNext;
   end

   // cnt tracks PRE strobes, POST samples (trigger included) or DONE reads.
   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      rdAccept  = 1'b0;
      trigFire  = 1'b0;
      case (state)
         IDLE: begin
            cntNext = '0;
            if (iArm) stateNext = PRE;
         end
         PRE: begin
            if (iSampleStrobe) begin
               if (cnt == pDepthBits'(pPreTrig - 1)) begin
                  stateNext = WAIT;
                  cntNext   = '0;
               end else begin
                  cntNext = cnt + 1'b1;
               end
            end
         end
         WAIT: begin
            if (iSampleStrobe && trigHit) begin
               trigFire = 1'b1;
               if (cPostSingle) begin
                  stateNext = DONE;
                  cntNext   = '0;
               end else begin
                  stateNext = POST;
                  cntNext   = pDepthBits'(1);
               end
            end
         end
         POST: begin
            if (iSampleStrobe) begin
               if (cnt == pDepthBits'(cPostLen - 1)) begin
                  stateNext = DONE;
                  cntNext   = '0;
               end else begin
                  cntNext = cnt + 1'b1;
               end
            end
         end
         DONE: begin
            if (iArm) begin
               stateNext = PRE;
               cntNext   = '0;
            end else if (iRdReq) begin
               rdAccept = 1'b1;
               cntNext  = cnt + 1'b1;
               if (cnt == pDepthBits'(cDepth - 1)) stateNext = IDLE;
            end
         end
         default: begin
            stateNext = IDLE;
            cntNext   = '0;
         end
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         wptr       <= '0;
         tptr       <= '0;
         cnt        <= '0;
         rPrev      <= '0;
         oRdValid   <= 1'b0;
         oArmed     <= 1'b0;
         oTriggered <= 1'b0;
         oDone      <= 1'b0;
      end else begin
         cnt        <= cntNext;
         oRdValid   <= rdAccept;
         oArmed     <= (stateNext == PRE)  || (stateNext == WAIT);
         oTriggered <= (stateNext == POST) || (stateNext == DONE);
         oDone      <= (stateNext == DONE);
         if (wrEn) begin
            wptr  <= wptr + 1'b1;
            rPrev <= iADC_Byte;
         end
         if (trigFire) tptr <= wptr;
      end
   end

   // Oldest retained sample sits pPreTrig slots before the trigger sample.
   assign rdAddr = tptr - pDepthBits'(pPreTrig) + cnt;

   scope_sample_ram #(
      .pDepthBits (pDepthBits)
   ) uRam (
      .iCLK    (iCLK),
      .iRST    (iRST),
      .iWrEn   (wrEn && !iRST),
      .iWrAddr (wptr),
      .iWrData (iADC_Byte),
      .iRdEn   (rdAccept),
      .iRdAddr (rdAddr),
      .oRdData (oRdData)
   );

endmodule
